mm_cache_mp: RTL

Parametrised shared direct-mapped write-back block cache that serves NUM_PORTS lower-level clients (ICache, DCache, more in future) through one round-robin arbiter, and talks to the next memory level over separate fill and evict handshakes. It generalises the two-port ICache/DCache main-memory cache to any client count. Clients both read blocks and write back evicted blocks; the cache write-allocates. It sits between the L1 caches and main memory.

---
 rtl/mm_cache_pkg.sv | 29 ++
 rtl/mm_cache_rr_arb.sv | 44 ++++
 rtl/mm_cache_mp.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mm_cache_pkg.sv
// mm_cache_pkg: shared types and helpers for the mm_cache_mp block cache.
//   ADDR_W       - client / memory address width
//   state_t      - controller FSM states
//   line_state_t - per-line valid/dirty flags
//   off_w/idx_w/port_w - field width helpers used for localparams
package mm_cache_pkg;
  localparam int ADDR_W = 32;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESP} state_t;

  typedef struct packed {
    logic valid;
    logic dirty;
  } line_state_t;

  // byte-offset bits inside one block
  function automatic int off_w(input int block_bits);
    return $clog2(block_bits / 8);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // port index width, at least one bit
  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mm_cache_rr_arb.sv
// mm_cache_rr_arb: round-robin arbiter for the mm_cache_mp client ports.
//   clk, rst_n - clock, async active-low reset (pointer returns to port 0)
//   req        - per-port request vector
//   advance    - grant is being taken this cycle; pointer moves past it
//   gnt        - one-hot grant
//   gnt_idx    - binary index of the granted port
//   gnt_any    - some port is requesting
module mm_cache_rr_arb import mm_cache_pkg::*; #(
  parameter  int NUM_PORTS = 2,
  localparam int PW        = port_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        gnt_idx,
  output logic                 gnt_any
);
  logic [PW-1:0] ptr;

  // first requester found scanning upward from ptr, wrapping
  always_comb begin
    int p;
    p       = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = (int'(ptr) + i) % NUM_PORTS;
      if (!gnt_any && req[p]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(p);
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (advance && gnt_any)
      ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/mm_cache_mp.sv
// mm_cache_mp: shared direct-mapped write-back, write-allocate block cache
// serving NUM_PORTS L1 clients through a round-robin arbiter.
//   req_i/wr_i/addr_i/data_i      - per-port block read / write-back requests
//   resp_valid_o/resp_addr_o/resp_data_o - one-cycle completion (data 0 on writes)
//   request_o/addr_out_request_o  - fill request to next level
//   request_valid_i/addr_in_request_i/data_in_request_i - fill return
//   evict_o/addr_out_evict_o/data_out_evict_o, evict_i - dirty victim write-back
//   hit_cnt_o/miss_cnt_o          - saturating lookup counters, built only
//                                   when MM_CACHE_PERF_EN is defined, else 0
module mm_cache_mp import mm_cache_pkg::*; #(
  parameter int NUM_PORTS  = 2,
  parameter int LINES      = 16,
  parameter int BLOCK_BITS = 512
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  wr_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]      addr_i,
  input  logic [NUM_PORTS-1:0][BLOCK_BITS-1:0]  data_i,
  output logic [NUM_PORTS-1:0]                  resp_valid_o,
  output logic [ADDR_W-1:0]                     resp_addr_o,
  output logic [BLOCK_BITS-1:0]                 resp_data_o,
  output logic                                  request_o,
  output logic [ADDR_W-1:0]                     addr_out_request_o,
  input  logic                                  request_valid_i,
  input  logic [ADDR_W-1:0]                     addr_in_request_i,
  input  logic [BLOCK_BITS-1:0]                 data_in_request_i,
  output logic                                  evict_o,
  output logic [ADDR_W-1:0]                     addr_out_evict_o,
  output logic [BLOCK_BITS-1:0]                 data_out_evict_o,
  input  logic                                  evict_i,
  output logic [31:0]                           hit_cnt_o,
  output logic [31:0]                           miss_cnt_o
);
  localparam int OW  = off_w(BLOCK_BITS);
  localparam int IXW = idx_w(LINES);
  localparam int TW  = ADDR_W - OW - IXW;
  localparam int PW  = port_w(NUM_PORTS);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << OW) - 1'b1);

  state_t                   state;
  logic [NUM_PORTS-1:0]     cur_oh;
  logic                     cur_wr;
  logic [ADDR_W-1:0]        cur_addr;
  logic [BLOCK_BITS-1:0]    cur_data;

  line_state_t [LINES-1:0]  lst;
  logic [TW-1:0]            tag_mem  [LINES];
  logic [BLOCK_BITS-1:0]    data_mem [LINES];

  logic [NUM_PORTS-1:0]     gnt;
  logic [PW-1:0]            gnt_idx;
  logic                     gnt_any, grant;

  logic [IXW-1:0]           line_idx;
  logic [TW-1:0]            line_tag;
  logic                     hit, victim_dirty, fill_ok;
  logic                     line_we, line_dirty, done, start_evict, start_fill;
  logic [BLOCK_BITS-1:0]    line_data, done_data;

  assign grant = gnt_any && (state == IDLE);

  mm_cache_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .req     (req_i),
    .advance (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign line_idx     = cur_addr[OW +: IXW];
  assign line_tag     = cur_addr[ADDR_W-1 -: TW];
  assign hit          = lst[line_idx].valid && (tag_mem[line_idx] == line_tag);
  assign victim_dirty = lst[line_idx].valid && lst[line_idx].dirty;
  // returns are matched on block address; offset bits are don't-care
  assign fill_ok      = request_valid_i &&
                        ((addr_in_request_i & BLK_MASK) == (cur_addr & BLK_MASK));

  // next-step decode: line write, completion, or start of upper-level traffic
  always_comb begin
    line_we     = 1'b0;
    line_dirty  = 1'b0;
    line_data   = cur_data;
    done        = 1'b0;
    done_data   = '0;
    start_evict = 1'b0;
    start_fill  = 1'b0;
    unique case (state)
      LOOKUP: begin
        if (hit) begin
          done = 1'b1;
          if (cur_wr) begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
          end else begin
            done_data = data_mem[line_idx];
          end
        end else if (victim_dirty) begin
          start_evict = 1'b1;
        end else if (!cur_wr) begin
          start_fill = 1'b1;
        end else begin
          // write miss over a clean/invalid line: allocate without a fill
          line_we    = 1'b1;
          line_dirty = 1'b1;
          done       = 1'b1;
        end
      end
      EVICT: begin
        if (evict_i) begin
          if (cur_wr) begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
            done       = 1'b1;
          end else begin
            start_fill = 1'b1;
          end
        end
      end
      FILL: begin
        if (fill_ok) begin
          line_we   = 1'b1;
          line_data = data_in_request_i;
          done      = 1'b1;
          done_data = data_in_request_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state              <= IDLE;
      cur_oh             <= '0;
      cur_wr             <= 1'b0;
      cur_addr           <= '0;
      cur_data           <= '0;
      lst                <= '0;
      resp_valid_o       <= '0;
      resp_addr_o        <= '0;
      resp_data_o        <= '0;
      request_o          <= 1'b0;
      addr_out_request_o <= '0;
      evict_o            <= 1'b0;
      addr_out_evict_o   <= '0;
      data_out_evict_o   <= '0;
    end else begin
      resp_valid_o <= '0;
      if (line_we) begin
        lst[line_idx].valid <= 1'b1;
        lst[line_idx].dirty <= line_dirty;
      end
      case (state)
        IDLE: begin
          if (grant) begin
            cur_oh   <= gnt;
            cur_wr   <= wr_i[gnt_idx];
            cur_addr <= addr_i[gnt_idx];
            cur_data <= data_i[gnt_idx];
            state    <= LOOKUP;
          end
        end
        RESP:    state <= IDLE;
        EVICT:   if (evict_i) evict_o <= 1'b0;
        FILL:    if (fill_ok) request_o <= 1'b0;
        default: ;
      endcase
      if (start_evict) begin
        evict_o          <= 1'b1;
        addr_out_evict_o <= {tag_mem[line_idx], line_idx, {OW{1'b0}}};
        data_out_evict_o <= data_mem[line_idx];
        state            <= EVICT;
      end
      if (start_fill) begin
        request_o          <= 1'b1;
        addr_out_request_o <= cur_addr & BLK_MASK;
        state              <= FILL;
      end
      if (done) begin
        resp_valid_o <= cur_oh;
        resp_addr_o  <= cur_addr;
        resp_data_o  <= done_data;
        state        <= RESP;
      end
    end
  end

  // tag/data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

`ifdef MM_CACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else if (miss_cnt != '1) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif
endmodule
